// File: rtl/reset_sequencer.sv
// Reset sequencer: asserts every domain reset asynchronously on rst low, then
// releases the domains one at a time in index order. Release begins after a
// 2-flop deassertion synchronizer and a minimum hold period, and later
// releases are spaced by a fixed gap. A four-phase software handshake
// (sw_rst_req / sw_rst_ack) re-runs the hold and release sequence from RUN.
module reset_sequencer #(
    parameter int N_DOMAINS = 3,
    parameter int STRETCH   = 8,
    parameter int GAP       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_rst_req,
    output logic [N_DOMAINS-1:0] rst_n_out,
    output logic                 ready,
    output logic                 sw_rst_ack
);

    localparam int MAXV = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CW   = $clog2(MAXV);

    localparam logic [CW-1:0] C_STRETCH_M1 = CW'(STRETCH - 1);
    localparam logic [CW-1:0] C_GAP_M1     = CW'(GAP - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_SW_HOLD = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [N_DOMAINS-1:0]   r_rst_n;
    logic [N_DOMAINS-1:0]   w_rst_n_nxt;
    logic                   r_ready;
    logic                   w_ready_nxt;
    logic                   r_ack;
    logic                   w_ack_nxt;
    logic                   r_sync1;
    logic                   r_rst_sync;
    logic [N_DOMAINS:0]     w_rst_ext;
    logic [N_DOMAINS-1:0]   w_rst_shift;
    logic                   w_last;

    // Deassertion synchronizer: cleared asynchronously, releases two edges after rst rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_sync1    <= 1'b1;
            r_rst_sync <= r_sync1;
        end
    end

    // Next release pattern: shift a one in at bit 0; written via a widened vector so
    // the same expression stays legal when there is only a single domain
    assign w_rst_ext   = {r_rst_n, 1'b1};
    assign w_rst_shift = w_rst_ext[N_DOMAINS-1:0];
    assign w_last      = &w_rst_shift;

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_rst_n <= '0;
            r_ready <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_ready <= w_ready_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    // Next-state and output logic; everything holds until the synchronizer releases
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rst_n_nxt = r_rst_n;
        w_ready_nxt = r_ready;
        w_ack_nxt   = r_ack;
        if (r_rst_sync) begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == C_STRETCH_M1) begin
                        w_cnt_nxt   = '0;
                        w_rst_n_nxt = w_rst_shift;
                        w_state_nxt = w_last ? S_RUN : S_RELEASE;
                        w_ready_nxt = w_last;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == C_GAP_M1) begin
                        w_cnt_nxt   = '0;
                        w_rst_n_nxt = w_rst_shift;
                        w_state_nxt = w_last ? S_RUN : S_RELEASE;
                        w_ready_nxt = w_last;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (sw_rst_req) begin
                        w_state_nxt = S_SW_HOLD;
                        w_cnt_nxt   = '0;
                        w_rst_n_nxt = '0;
                        w_ready_nxt = 1'b0;
                        w_ack_nxt   = 1'b1;
                    end
                end
                S_SW_HOLD: begin
                    // Counter saturates at the hold limit while the request stays high
                    if (r_cnt == C_STRETCH_M1) begin
                        if (!sw_rst_req) begin
                            w_cnt_nxt   = '0;
                            w_ack_nxt   = 1'b0;
                            w_rst_n_nxt = w_rst_shift;
                            w_state_nxt = w_last ? S_RUN : S_RELEASE;
                            w_ready_nxt = w_last;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                    w_rst_n_nxt = '0;
                    w_ready_nxt = 1'b0;
                    w_ack_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign rst_n_out  = r_rst_n;
    assign ready      = r_ready;
    assign sw_rst_ack = r_ack;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on, async assert, software
// handshake (short and long request), abort mid-release, ready pulse, and the
// small / zero-gap parameter sets on extra instances sharing clk and rst.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       no_req = 1'b0;
    logic [2:0] rn3;
    logic       rdy3, ack3;
    logic [0:0] rn1;
    logic       rdy1, ack1;
    logic [3:0] rn4;
    logic       rdy4, ack4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.N_DOMAINS(3), .STRETCH(8), .GAP(4)) dut (
        .clk(clk), .rst(rst), .sw_rst_req(req),
        .rst_n_out(rn3), .ready(rdy3), .sw_rst_ack(ack3)
    );

    reset_sequencer #(.N_DOMAINS(1), .STRETCH(2), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .sw_rst_req(no_req),
        .rst_n_out(rn1), .ready(rdy1), .sw_rst_ack(ack1)
    );

    reset_sequencer #(.N_DOMAINS(4), .STRETCH(8), .GAP(1)) dut4 (
        .clk(clk), .rst(rst), .sw_rst_req(no_req),
        .rst_n_out(rn4), .ready(rdy4), .sw_rst_ack(ack4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Domain i is released at edge E(2+STRETCH+i*GAP) counted from rst rising
    function automatic logic [31:0] exp_mask(input int k, input int n, input int s, input int g);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < n; i++)
            if (k >= 2 + s + i * g) m[i] = 1'b1;
        return m;
    endfunction

    // Check edges E1..En after rst was raised between edges
    task automatic run_seq(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            chk("d3_rst_n", 32'(rn3), exp_mask(k, 3, 8, 4));
            chk("d3_ready", 32'(rdy3), 32'(k >= 18));
            chk("d3_ack",   32'(ack3), 32'd0);
            chk("d1_rst_n", 32'(rn1), exp_mask(k, 1, 2, 1));
            chk("d1_ready", 32'(rdy1), 32'(k >= 4));
            chk("d4_rst_n", 32'(rn4), exp_mask(k, 4, 8, 1));
            chk("d4_ready", 32'(rdy4), 32'(k >= 13));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog @%0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset values
        #1 rst = 1'b0;
        #1;
        chk("rst_rst_n", 32'(rn3), 32'd0);
        chk("rst_ready", 32'(rdy3), 32'd0);
        chk("rst_ack",   32'(ack3), 32'd0);
        chk("rst_d4",    32'(rn4), 32'd0);
        repeat (3) @(posedge clk);

        // Power-on sequence
        @(negedge clk); rst = 1'b1;
        run_seq(20);

        // Async assert mid-cycle while in RUN
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("async_rst_n", 32'(rn3), 32'd0);
        chk("async_ready", 32'(rdy3), 32'd0);
        chk("async_d4",    32'(rn4), 32'd0);
        @(negedge clk); rst = 1'b1;
        run_seq(20);

        // Software reset with a one-cycle request, sampled at edge R
        @(negedge clk); req = 1'b1;
        @(posedge clk); #1;
        chk("sw1_rst_n", 32'(rn3), 32'd0);
        chk("sw1_ack",   32'(ack3), 32'd1);
        chk("sw1_ready", 32'(rdy3), 32'd0);
        req = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk); #1;
            chk("sw1_seq_rst_n", 32'(rn3), exp_mask(j + 2, 3, 8, 4));
            chk("sw1_seq_ack",   32'(ack3), 32'(j < 8));
            chk("sw1_seq_ready", 32'(rdy3), 32'(j >= 16));
        end

        // Software reset with the request held for 20 edges
        @(negedge clk); req = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            chk("swl_hold_rst_n", 32'(rn3), 32'd0);
            chk("swl_hold_ack",   32'(ack3), 32'd1);
        end
        req = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            @(posedge clk); #1;
            chk("swl_rel_rst_n", 32'(rn3), exp_mask(j + 9, 3, 8, 4));
            chk("swl_rel_ack",   32'(ack3), 32'd0);
            chk("swl_rel_ready", 32'(rdy3), 32'(j >= 9));
        end

        // Abort at E15 with domain 1 released
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("abort_pre", 32'(rn3), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("abort_rst_n", 32'(rn3), 32'd0);
        chk("abort_ready", 32'(rdy3), 32'd0);
        @(negedge clk); rst = 1'b1;
        run_seq(20);

        // Request held through the whole release: ready pulses for exactly one cycle
        @(negedge clk); rst = 1'b0; req = 1'b1;
        @(negedge clk); rst = 1'b1;
        repeat (17) @(posedge clk);
        @(posedge clk); #1;
        chk("pulse_e18_rst_n", 32'(rn3), 32'd7);
        chk("pulse_e18_ready", 32'(rdy3), 32'd1);
        chk("pulse_e18_ack",   32'(ack3), 32'd0);
        @(posedge clk); #1;
        chk("pulse_e19_rst_n", 32'(rn3), 32'd0);
        chk("pulse_e19_ready", 32'(rdy3), 32'd0);
        chk("pulse_e19_ack",   32'(ack3), 32'd1);
        req = 1'b0;
        repeat (6) @(posedge clk);
        @(posedge clk); #1;
        chk("pulse_r7_rst_n", 32'(rn3), 32'd0);
        chk("pulse_r7_ack",   32'(ack3), 32'd1);
        @(posedge clk); #1;
        chk("pulse_r8_rst_n", 32'(rn3), 32'd1);
        chk("pulse_r8_ack",   32'(ack3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset controller for the design's flop domains. It asserts all domain resets asynchronously on `rst` and releases them synchronously after a 2-flop deassertion synchronizer and a minimum hold period. Domains are released one at a time in index order, with a fixed gap between releases. A four-phase software reset handshake re-runs the same sequence without toggling `rst`. It sits at the top of the clock domain and drives the active-low reset of every downstream block.

## Interface
- `N_DOMAINS`, default 3: number of sequenced reset outputs; must be ≥1.
- `STRETCH`, default 8: minimum cycles all domains are held in reset; must be ≥2.
- `GAP`, default 4: cycles between consecutive domain releases; must be ≥1.
- `clk`  input  1  clock; all sequencing on posedge.
- `rst`  input  1  reset, asynchronous, active-low.
- `sw_rst_req`  input  1  software reset request, synchronous to `clk`, level.
- `rst_n_out`  output  N_DOMAINS  active-low domain resets; bit 0 is released first.
- `ready`  output  1  high when all domains are released (state RUN).
- `sw_rst_ack`  output  1  software reset acknowledge.

## Operation
- Synchronizer:
  - Two flops, D=1, both asynchronously cleared by `rst` low.
  - `rst_sync` is the second stage.
  - The FSM and counter advance only while `rst_sync`=1.
- States: HOLD, RELEASE, RUN, SW_HOLD. A single counter `cnt` has width clog2(max(STRETCH,GAP)).
- `rst` low, asynchronous, from any state:
  - state=HOLD, cnt=0, synchronizer cleared.
  - `rst_n_out`=0 (all bits), `ready`=0, `sw_rst_ack`=0.
  - These are the reset values of every output.
- HOLD: cnt increments each enabled edge. At the edge where cnt==STRETCH-1, the block enters RELEASE: `rst_n_out[0]`=1 and cnt=0.
- RELEASE:
  - cnt increments each edge.
  - At an edge where cnt==GAP-1, the next domain bit is set to 1 and cnt=0.
  - The edge that releases the last bit also enters RUN and sets `ready`=1.
  - With N_DOMAINS=1, the HOLD exit edge enters RUN directly.
- RUN: `sw_rst_req` is sampled every edge. If it is 1, the block enters SW_HOLD:
  - all `rst_n_out`=0 synchronously.
  - `ready`=0, `sw_rst_ack`=1, cnt=0.
- SW_HOLD:
  - cnt increments and saturates at STRETCH-1.
  - At an edge where cnt==STRETCH-1 and `sw_rst_req`=0, the block enters RELEASE: `rst_n_out[0]`=1, `sw_rst_ack`=0, cnt=0.
  - If `sw_rst_req` is still 1, the block stays in SW_HOLD with ack high.
- `sw_rst_req` is ignored in HOLD and RELEASE. A request held high through RELEASE is taken at the first RUN edge, so `ready` pulses high for exactly one cycle.
- Released domain bits never re-assert except by `rst` low or by entering SW_HOLD.
- Released bits are monotonic within a sequence: `rst_n_out` takes only the values 0, then low bits set contiguously.

## Timing
- All `rst_n_out` assertion on `rst` low is combinational through the async clear, with zero clock latency.
- Deassertion path:
  - E1 is the first posedge after `rst` rises; `rst_sync`=1 after E2.
  - Domain k releases at edge E2+STRETCH+k·GAP.
  - Defaults: d0 at E10, d1 at E14, d2 at E18; `ready`=1 at E18.
- A `rst` rise inside the posedge setup window may add one cycle (E1 slips). The bench must allow ±1 cycle on the first release only.
- SW path:
  - Request sampled at edge R.
  - Resets asserted and ack high after R.
  - Earliest d0 release at R+STRETCH, and only if req is low at that edge.
  - Then the same GAP spacing applies.
- Four-phase handshake: requester raises req, waits for ack=1, drops req. Ack falls at the release edge.
- `rst` low mid-RELEASE or mid-SW_HOLD aborts immediately to the reset values. The next sequence restarts from E1.

## Test plan
- Power-on, defaults: `rst` low 3 cycles then high → `rst_n_out` 000 until E10, then 001 at E10, 011 at E14, 111 at E18, with `ready` rising at E18.
- Async assert: in RUN, drop `rst` mid-cycle between edges → `rst_n_out`=000, `ready`=0 before the next posedge. Raise it → sequence repeats with identical spacing.
- SW reset, 1-cycle req: req=1 at edge R in RUN → after R `rst_n_out`=000, ack=1 → d0 at R+8, ack=0 at R+8 → `ready` at R+16.
- SW reset, long req: req held 20 cycles → ack stays 1 and resets stay 000 until the first edge with req=0; d0 releases at that edge.
- Abort: `rst` low at E15 (domain 1 released) → all 000 immediately; a fresh sequence gives d0 at new E2+8.
- Parameters N_DOMAINS=1, STRETCH=2, GAP=1 → d0 and `ready` at E4. With N_DOMAINS=4, GAP=1, the bits release on consecutive edges E10..E13.
